// File: rtl/aibcr3_dcc_seq.sv
// aibcr3_dcc_seq: duty-cycle-correction calibration sequencer
// Ports:
//   clk      - block clock, all state changes on its rising edge
//   rst_n    - asynchronous active-low reset
//   dcc_en   - level enable: 1 starts and holds calibration, 0 aborts it
//   tmo_cfg  - request timeout in clk cycles, 0 disables the timeout
//   dcc_done - completion flag from the downstream DCC stage (asynchronous)
//   dcc_req  - request / active-low clear to the downstream DCC stage
//   dcc_lock - calibration complete and holding
//   dcc_err  - timeout exhausted or lock lost
//   busy     - sequencer is settling or requesting
// Optional feature: define AIBCR3_DCC_SEQ_RETRY_EN to retry timed-out requests
// up to MAX_RETRY extra times before flagging an error.
module aibcr3_dcc_seq #(
    parameter int SETTLE_CYC = 4,
    parameter int TMO_W      = 10,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dcc_en,
    input  logic [TMO_W-1:0] tmo_cfg,
    input  logic             dcc_done,
    output logic             dcc_req,
    output logic             dcc_lock,
    output logic             dcc_err,
    output logic             busy
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    typedef enum logic [2:0] {IDLE, SETTLE, REQ, LOCKED, ERR} state_t;
    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic             sync1_q, sync2_q, done_s;
    logic             req_q, lock_q, err_q, busy_q;
    logic             tmo_hit, retry_ok;
    if (SETTLE_CYC < 1 || TMO_W < 1 || MAX_RETRY < 0) begin : g_bad_param
        $error("aibcr3_dcc_seq: illegal parameter value");
    end
    assign done_s   = sync2_q;
    // done_s is excluded here so a completion always beats a coincident timeout
    assign tmo_hit  = !done_s && (tmo_cfg != '0) && (timer_q == tmo_cfg - TMO_W'(1));
    assign dcc_req  = req_q;
    assign dcc_lock = lock_q;
    assign dcc_err  = err_q;
    assign busy     = busy_q;
`ifdef AIBCR3_DCC_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
    assign retry_ok = retry_q < RW'(MAX_RETRY);
    always_comb begin
        retry_d = retry_q;
        if (!dcc_en || state_q == IDLE)
            retry_d = '0;
        else if (state_q == REQ && tmo_hit && retry_ok)
            retry_d = retry_q + RW'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retry_q <= '0;
        else        retry_q <= retry_d;
    end
`else
    assign retry_ok = 1'b0;
`endif
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        timer_d  = timer_q;
        if (!dcc_en) begin
            state_d  = IDLE;
            settle_d = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    timer_d  = '0;
                end
                SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYC - 1)) begin
                        state_d = REQ;
                        timer_d = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                REQ: begin
                    timer_d = (&timer_q) ? timer_q : timer_q + TMO_W'(1);
                    if (done_s) begin
                        state_d = LOCKED;
                    end else if (tmo_hit) begin
                        state_d  = retry_ok ? SETTLE : ERR;
                        settle_d = '0;
                    end
                end
                LOCKED: state_d = done_s ? LOCKED : ERR;
                default: state_d = ERR;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            timer_q  <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            req_q    <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            timer_q  <= timer_d;
            sync1_q  <= dcc_done;
            sync2_q  <= sync1_q;
            req_q    <= (state_d == REQ) || (state_d == LOCKED);
            lock_q   <= state_d == LOCKED;
            err_q    <= state_d == ERR;
            busy_q   <= (state_d == SETTLE) || (state_d == REQ);
        end
    end
endmodule
